// File: rtl/fighter_action_sequencer.sv
// Per-player action controller: turns held move/attack keys into frame-synchronous
// movement and attack-phase commands, with hit-stun interrupt and a one-deep attack buffer.
module fighter_action_sequencer #(
   parameter int unsigned CNT_W       = 5,
   parameter int unsigned WINDUP1     = 4,
   parameter int unsigned ACTIVE1     = 3,
   parameter int unsigned RECOVER1    = 6,
   parameter int unsigned WINDUP2     = 8,
   parameter int unsigned ACTIVE2     = 4,
   parameter int unsigned RECOVER2    = 12,
   parameter int unsigned STUN_FRAMES = 10
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic       left_on,
   input  logic       right_on,
   input  logic       atk1_on,
   input  logic       atk2_on,
   input  logic       hit_pulse,
   output logic [1:0] move_dir,
   output logic [2:0] phase,
   output logic       attack_id,
   output logic       hitbox_en,
   output logic       busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WINDUP  = 3'd1;
   localparam logic [2:0] S_ACTIVE  = 3'd2;
   localparam logic [2:0] S_RECOVER = 3'd3;
   localparam logic [2:0] S_STUN    = 3'd4;

   // Counter load value (length-1) for a given attack and phase.
   function automatic logic [CNT_W-1:0] load_val(input logic id, input logic [2:0] st);
      int unsigned len;
      case (st)
         S_WINDUP:  len = id ? WINDUP2 : WINDUP1;
         S_ACTIVE:  len = id ? ACTIVE2 : ACTIVE1;
         S_RECOVER: len = id ? RECOVER2 : RECOVER1;
         default:   len = STUN_FRAMES;
      endcase
      return CNT_W'(len - 1);
   endfunction

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             id_q, id_d;
   logic             buf_valid_q, buf_valid_d;
   logic             buf_id_q, buf_id_d;
   logic             prev1_q, prev1_d;
   logic             prev2_q, prev2_d;
   logic             hit_pend_q, hit_pend_d;
   logic [1:0]       move_q, move_d;

   logic press1, press2, press_any, press_id, hit_now, start, start_id;

   // Next-state logic: everything except hit capture advances only on frame ticks.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      id_d        = id_q;
      buf_valid_d = buf_valid_q;
      buf_id_d    = buf_id_q;
      prev1_d     = prev1_q;
      prev2_d     = prev2_q;
      move_d      = move_q;
      hit_pend_d  = hit_pend_q | hit_pulse;
      press1      = atk1_on & ~prev1_q;
      press2      = atk2_on & ~prev2_q;
      press_any   = press1 | press2;
      press_id    = ~press1;  // atk1 wins a same-tick tie
      hit_now     = hit_pend_q | hit_pulse;
      start       = 1'b0;
      start_id    = 1'b0;

      if (frame_tick) begin
         prev1_d    = atk1_on;
         prev2_d    = atk2_on;
         hit_pend_d = 1'b0;
         move_d     = 2'b00;
         if (!enable) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            buf_valid_d = 1'b0;
         end else if (hit_now) begin
            state_d     = S_STUN;
            cnt_d       = load_val(1'b0, S_STUN);
            buf_valid_d = 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (buf_valid_q) begin
                     start    = 1'b1;
                     start_id = buf_id_q;
                  end else if (press_any) begin
                     start    = 1'b1;
                     start_id = press_id;
                  end else if (left_on && !right_on) begin
                     move_d = 2'b01;
                  end else if (right_on && !left_on) begin
                     move_d = 2'b10;
                  end
               end
               S_WINDUP, S_ACTIVE: begin
                  if (cnt_q == '0) begin
                     state_d = state_q + 3'd1;
                     cnt_d   = load_val(id_q, state_q + 3'd1);
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               S_RECOVER: begin
                  if (press_any) begin
                     buf_valid_d = 1'b1;
                     buf_id_d    = press_id;
                  end
                  if (cnt_q == '0) begin
                     // A buffered attack chains straight into windup, skipping IDLE.
                     if (press_any || buf_valid_q) begin
                        start    = 1'b1;
                        start_id = press_any ? press_id : buf_id_q;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               S_STUN: begin
                  if (cnt_q == '0) state_d = S_IDLE;
                  else cnt_d = cnt_q - 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
            if (start) begin
               state_d     = S_WINDUP;
               id_d        = start_id;
               cnt_d       = load_val(start_id, S_WINDUP);
               buf_valid_d = 1'b0;
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         id_q        <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_id_q    <= 1'b0;
         prev1_q     <= 1'b0;
         prev2_q     <= 1'b0;
         hit_pend_q  <= 1'b0;
         move_q      <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         id_q        <= id_d;
         buf_valid_q <= buf_valid_d;
         buf_id_q    <= buf_id_d;
         prev1_q     <= prev1_d;
         prev2_q     <= prev2_d;
         hit_pend_q  <= hit_pend_d;
         move_q      <= move_d;
      end
   end

   // Outputs decode directly from registered state.
   always_comb begin
      move_dir  = move_q;
      phase     = state_q;
      attack_id = id_q;
      hitbox_en = (state_q == S_ACTIVE);
      busy      = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Self-checking bench for fighter_action_sequencer: directed scenarios plus a randomized
// run, all compared against a tick-level behavioural model of the action rules.
module tb_fighter_action_sequencer;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       enable = 1'b1;
   logic       left_on = 1'b0, right_on = 1'b0, atk1_on = 1'b0, atk2_on = 1'b0;
   logic       hit_pulse = 1'b0;
   logic [1:0] move_dir;
   logic [2:0] phase;
   logic       attack_id, hitbox_en, busy;

   int nvec = 0;
   int nerr = 0;

   fighter_action_sequencer dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .enable(enable),
      .left_on(left_on), .right_on(right_on), .atk1_on(atk1_on), .atk2_on(atk2_on),
      .hit_pulse(hit_pulse), .move_dir(move_dir), .phase(phase), .attack_id(attack_id),
      .hitbox_en(hitbox_en), .busy(busy)
   );

   always #5 Clk = ~Clk;

   // Behavioural model: phase name number plus frames remaining in that phase.
   int m_phase, m_left, m_id, m_buf_id, m_move;
   bit m_buf, m_prev1, m_prev2, m_hit;

   function automatic int plen(input int id, input int ph);
      case (ph)
         1:       return (id != 0) ? 8 : 4;
         2:       return (id != 0) ? 4 : 3;
         3:       return (id != 0) ? 12 : 6;
         default: return 10;
      endcase
   endfunction

   function automatic logic [6:0] model_outs();
      logic [1:0] mv;
      logic [2:0] ph;
      mv = 2'(m_move);
      ph = 3'(m_phase);
      return {mv, ph, logic'(m_phase == 2), logic'(m_phase != 0)};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_left = 0; m_id = 0; m_buf_id = 0; m_move = 0;
      m_buf = 0; m_prev1 = 0; m_prev2 = 0; m_hit = 0;
   endtask

   task automatic model_start(input int id);
      m_phase = 1; m_id = id; m_left = plen(id, 1); m_buf = 0;
   endtask

   task automatic model_step(input bit l, r, a1, a2, en, hit);
      bit p1, p2, pany, hitnow;
      int pid;
      p1 = a1 && !m_prev1;
      p2 = a2 && !m_prev2;
      m_prev1 = a1; m_prev2 = a2;
      pany = p1 || p2;
      pid = p1 ? 0 : 1;
      hitnow = m_hit || hit;
      m_hit = 0;
      m_move = 0;
      if (!en) begin
         m_phase = 0; m_buf = 0;
      end else if (hitnow) begin
         m_phase = 4; m_left = 10; m_buf = 0;
      end else if (m_phase == 0) begin
         if (m_buf) model_start(m_buf_id);
         else if (pany) model_start(pid);
         else if (l != r) m_move = l ? 1 : 2;
      end else begin
         if (m_phase == 3 && pany) begin m_buf = 1; m_buf_id = pid; end
         m_left--;
         if (m_left == 0) begin
            if (m_phase == 1 || m_phase == 2) begin
               m_phase++; m_left = plen(m_id, m_phase);
            end else if (m_phase == 3 && m_buf) begin
               model_start(m_buf_id);
            end else begin
               m_phase = 0;
            end
         end
      end
   endtask

   // One frame tick with given inputs, preceded by a random idle gap; returns at the
   // following falling edge, where the updated outputs are stable.
   task automatic do_tick(input bit l, r, a1, a2, en, hit);
      repeat ($urandom_range(2)) @(negedge Clk);
      @(negedge Clk);
      left_on = l; right_on = r; atk1_on = a1; atk2_on = a2; enable = en;
      frame_tick = 1'b1; hit_pulse = hit;
      model_step(l, r, a1, a2, en, hit);
      @(negedge Clk);
      frame_tick = 1'b0; hit_pulse = 1'b0;
   endtask

   // Hit pulse between ticks.
   task automatic hit_mid();
      @(negedge Clk);
      hit_pulse = 1'b1; m_hit = 1;
      @(negedge Clk);
      hit_pulse = 1'b0;
   endtask

   task automatic settle();
      do_tick(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 40 && m_phase != 0; i++) do_tick(0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_reset();
      nvec++;
      if ({move_dir, phase, hitbox_en, busy, attack_id} !== 8'h00) begin
         nerr++;
         $display("FAIL reset_state: got %b expected 00000000",
                  {move_dir, phase, hitbox_en, busy, attack_id});
      end
      do_tick(0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 5; i++) do_tick(0, 0, 1, 0, 1, 0);
      nvec++;
      if (phase !== 3'd2 || hitbox_en !== 1'b1) begin
         nerr++;
         $display("FAIL reset_reach_active: phase=%0d hitbox=%b expected 2/1", phase, hitbox_en);
      end
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      nvec++;
      if ({move_dir, phase, hitbox_en, busy, attack_id} !== 8'h00) begin
         nerr++;
         $display("FAIL reset_async: got %b expected 00000000",
                  {move_dir, phase, hitbox_en, busy, attack_id});
      end
      model_reset();
      atk1_on = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      do_tick(0, 0, 0, 0, 1, 0);
      nvec++;
      if (phase !== 3'd0 || move_dir !== 2'b00) begin
         nerr++;
         $display("FAIL reset_release: phase=%0d move=%b expected 0/00", phase, move_dir);
      end
   endtask

   task automatic test_movement();
      logic [1:0] exp_mv [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
      bit l, r;
      for (int i = 0; i < 5; i++) begin
         l = (i < 4);
         r = (i >= 3);
         do_tick(l, r, 0, 0, 1, 0);
         nvec++;
         if (move_dir !== exp_mv[i] || {move_dir, phase, hitbox_en, busy} !== model_outs()) begin
            nerr++;
            $display("FAIL movement[%0d]: move=%b expected %b", i, move_dir, exp_mv[i]);
         end
      end
      settle();
   endtask

   task automatic test_attack1();
      int n1 = 0, n2 = 0, n3 = 0, nbox = 0;
      for (int i = 0; i < 30; i++) begin
         do_tick(0, 0, 1, 0, 1, 0);
         if (phase == 3'd1) n1++;
         if (phase == 3'd2) n2++;
         if (phase == 3'd3) n3++;
         if (hitbox_en === 1'b1) nbox++;
         nvec++;
         if ({move_dir, phase, hitbox_en, busy} !== model_outs() ||
             (m_phase != 0 && attack_id !== 1'b0)) begin
            nerr++;
            $display("FAIL attack1_tick[%0d]: phase=%0d id=%b expected phase %0d id 0",
                     i, phase, attack_id, m_phase);
         end
      end
      nvec++;
      if (n1 != 4 || n2 != 3 || n3 != 6 || nbox != 3) begin
         nerr++;
         $display("FAIL attack1_lengths: got %0d/%0d/%0d box %0d expected 4/3/6 box 3",
                  n1, n2, n3, nbox);
      end
      settle();
   endtask

   task automatic test_buffer();
      int gap = 0, nw2 = 0, i = 0;
      bit seen_rec = 0, pressed = 0, a2;
      // Press attack 1, then tap attack 2 during windup (must be ignored).
      do_tick(0, 0, 1, 0, 1, 0);
      do_tick(0, 0, 0, 1, 1, 0);
      do_tick(0, 0, 0, 0, 1, 0);
      while (i < 60 && !(seen_rec && m_phase == 0)) begin
         a2 = (m_phase == 3 && m_left == 4 && !pressed);
         if (a2) pressed = 1;
         do_tick(0, 0, 0, a2, 1, 0);
         if (phase == 3'd3 && attack_id == 1'b0) seen_rec = 1;
         if (seen_rec && phase == 3'd0 && nw2 == 0) gap++;
         if (phase == 3'd1 && attack_id == 1'b1) nw2++;
         nvec++;
         if ({move_dir, phase, hitbox_en, busy} !== model_outs() ||
             (m_phase inside {1, 2, 3} && attack_id !== 1'(m_id))) begin
            nerr++;
            $display("FAIL buffer_tick[%0d]: phase=%0d id=%b expected phase %0d id %0d",
                     i, phase, attack_id, m_phase, m_id);
         end
         i++;
      end
      nvec++;
      if (gap != 0 || nw2 != 8 || phase !== 3'd0) begin
         nerr++;
         $display("FAIL buffer_chain: idle gap %0d windup2 %0d final phase %0d expected 0/8/0",
                  gap, nw2, phase);
      end
   endtask

   task automatic test_stun();
      int nstun = 0, i = 0;
      bit rehit = 0;
      do_tick(0, 0, 0, 1, 1, 0);
      while (i < 20 && m_phase != 2) begin do_tick(0, 0, 0, 0, 1, 0); i++; end
      hit_mid();
      do_tick(0, 0, 0, 0, 1, 0);
      nvec++;
      if (phase !== 3'd4 || hitbox_en !== 1'b0 || busy !== 1'b1) begin
         nerr++;
         $display("FAIL stun_entry: phase=%0d hitbox=%b expected 4/0", phase, hitbox_en);
      end
      nstun = (phase == 3'd4) ? 1 : 0;
      i = 0;
      while (i < 40 && m_phase != 0) begin
         if (nstun == 5 && !rehit) begin hit_mid(); rehit = 1; end
         do_tick(0, 0, 0, 0, 1, 0);
         if (phase == 3'd4) nstun++;
         nvec++;
         if ({move_dir, phase, hitbox_en, busy} !== model_outs()) begin
            nerr++;
            $display("FAIL stun_tick[%0d]: phase=%0d expected %0d", i, phase, m_phase);
         end
         i++;
      end
      nvec++;
      if (nstun != 15) begin
         nerr++;
         $display("FAIL stun_length: got %0d stun ticks expected 15", nstun);
      end
   endtask

   task automatic test_simultaneous();
      int nbusy = 0, i = 0;
      settle();
      do_tick(0, 0, 1, 1, 1, 0);
      nvec++;
      if (phase !== 3'd1 || attack_id !== 1'b0) begin
         nerr++;
         $display("FAIL simul_tie: phase=%0d id=%b expected 1/0", phase, attack_id);
      end
      settle();
      do_tick(0, 0, 1, 0, 1, 1);
      nvec++;
      if (phase !== 3'd4) begin
         nerr++;
         $display("FAIL simul_hit_press: phase=%0d expected 4", phase);
      end
      settle();
      do_tick(0, 0, 1, 0, 1, 0);
      while (i < 30 && !(m_phase == 3 && m_left < 5)) begin do_tick(0, 0, 0, 0, 1, 0); i++; end
      do_tick(0, 0, 0, 1, 1, 0);
      do_tick(0, 0, 0, 0, 0, 0);
      nvec++;
      if (phase !== 3'd0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL simul_disable: phase=%0d busy=%b expected 0/0", phase, busy);
      end
      for (int k = 0; k < 20; k++) begin
         do_tick(0, 0, 0, 0, 1, 0);
         if (busy !== 1'b0) nbusy++;
      end
      nvec++;
      if (nbusy != 0) begin
         nerr++;
         $display("FAIL simul_buffer_cleared: %0d busy ticks expected 0", nbusy);
      end
   endtask

   task automatic test_random();
      bit l, r, a1, a2, en, hit;
      for (int i = 0; i < 400; i++) begin
         l = ($urandom_range(2) == 0);
         r = ($urandom_range(2) == 0);
         a1 = ($urandom_range(3) == 0);
         a2 = ($urandom_range(3) == 0);
         en = ($urandom_range(24) != 0);
         hit = ($urandom_range(29) == 0);
         if ($urandom_range(29) == 0) hit_mid();
         do_tick(l, r, a1, a2, en, hit);
         nvec++;
         if ({move_dir, phase, hitbox_en, busy} !== model_outs() ||
             (m_phase inside {1, 2, 3} && attack_id !== 1'(m_id))) begin
            nerr++;
            $display("FAIL random[%0d]: move=%b phase=%0d id=%b expected move=%0d phase=%0d id=%0d",
                     i, move_dir, phase, attack_id, m_move, m_phase, m_id);
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      test_reset();
      test_movement();
      test_attack1();
      test_buffer();
      test_stun();
      test_simultaneous();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fighter_action_sequencer.md
Name: fighter_action_sequencer

Overview:
- Per-player action controller: one instance per player, fed by the held-key flags from the keycode decoder.
- Converts held move/attack keys into frame-synchronous movement and attack-phase commands.
- Runs an attack state machine (windup/active/recovery), a hit-stun interrupt and a one-deep attack buffer.
- Outputs drive the sprite/animation selector and the hitbox/collision logic.

Parameters:
- CNT_W, 5, width of phase frame counter
- WINDUP1, 4, attack 1 windup length in frames
- ACTIVE1, 3, attack 1 active (hitbox live) length in frames
- RECOVER1, 6, attack 1 recovery length in frames
- WINDUP2, 8, attack 2 windup length in frames
- ACTIVE2, 4, attack 2 active length in frames
- RECOVER2, 12, attack 2 recovery length in frames
- STUN_FRAMES, 10, hit-stun length in frames
- All lengths are >=1 and <= 2^CNT_W.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-Clk pulse per video frame
- enable  in  1  fight in progress; low = controls frozen
- left_on  in  1  held left key
- right_on  in  1  held right key
- atk1_on  in  1  held attack-1 key
- atk2_on  in  1  held attack-2 key
- hit_pulse  in  1  one-Clk pulse from collision: this player was hit
- move_dir  out  2  00 none, 01 left, 10 right
- phase  out  3  0 IDLE, 1 WINDUP, 2 ACTIVE, 3 RECOVER, 4 STUN
- attack_id  out  1  0 = attack 1, 1 = attack 2; valid when phase is 1..3
- hitbox_en  out  1  high only in ACTIVE
- busy  out  1  phase != IDLE

Behaviour:
- Reset (async, Reset_n=0):
  - state IDLE, counter 0, buffer empty, key-sample regs 0, hit_pending 0.
  - All outputs 0.
- State, counter, buffer and outputs change only on Clk edges where frame_tick=1 ("tick"). Registered outputs show the new state one Clk after the tick cycle.
- hit_pulse on any Clk sets hit_pending. hit_pending is consumed and cleared on the next tick. A hit_pulse coinciding with a tick is consumed on that same tick.
- Attack edges:
  - atk1/atk2 are sampled each tick.
  - Press = sampled now & ~previous sample; holding a key never retriggers.
  - Presses on the same tick: atk1 wins, atk2 is dropped.
- Phase counter:
  - Loaded with LEN-1 on phase entry, decremented each tick.
  - The phase exits on the tick where counter==0, so each phase lasts exactly LEN ticks.
- Tick priority (highest first):
  - enable=0: go to IDLE, clear buffer, move_dir=00.
  - hit_pending: go to STUN, counter=STUN_FRAMES-1, clear buffer. A hit during STUN restarts stun.
  - Normal FSM below.
- IDLE:
  - A press (or a buffered press, buffer first) selects WINDUP with attack_id set and counter=WINDUPx-1. Buffer is cleared.
  - Otherwise movement: left only -> 01; right only -> 10; both or neither -> 00.
  - move_dir is forced to 00 in every non-IDLE state and on the tick an attack starts.
- WINDUP -> ACTIVE -> RECOVER -> IDLE, each on counter==0, loading the next length for the latched attack_id.
- Buffer:
  - A press during RECOVER is stored (atk1 wins a tie; a later press overwrites).
  - Presses in WINDUP, ACTIVE or STUN are discarded.
  - On RECOVER exit the buffered attack starts directly: next state WINDUP, not IDLE.
- STUN: on counter==0 -> IDLE; buffer stays empty.
- hitbox_en = (state==ACTIVE); busy = (state!=IDLE).

Test Plan:
- Reset mid-attack: assert Reset_n=0 during ACTIVE -> all outputs 0 immediately (async); after release, IDLE and move_dir=00.
- Movement: hold left 3 ticks, then left+right 1 tick, then right -> move_dir 01,01,01,00,10.
- Attack 1 with defaults: atk1 pressed and held 30 ticks -> phase 1 for 4 ticks, 2 for 3 ticks (hitbox_en=1), 3 for 6 ticks, then 0 for the rest of the hold (no retrigger).
- Buffer: atk2 pressed during attack-1 RECOVER -> after the last RECOVER tick, phase=1 with attack_id=1, 8 windup ticks, no IDLE tick in between; the same press during WINDUP is ignored.
- Hit stun: hit_pulse mid-cycle during attack-2 ACTIVE -> next tick phase=4, hitbox_en=0 for 10 ticks, then IDLE. A second hit_pulse at stun tick 5 extends stun to 15 ticks total.
- Simultaneous events:
  - atk1 and atk2 rise on the same tick -> attack_id=0.
  - hit_pulse on the same tick as an attack press -> STUN wins.
  - enable=0 during RECOVER with a buffered attack -> IDLE, buffer empty, no attack after enable returns.
